alu_apb_master: RTL and testbench
=================================

# alu_apb_master

Command-to-APB master bridge that sits directly upstream of the ALU register slave. It accepts single read/write commands on a valid/ready interface and converts each one into one APB transfer (SETUP then ACCESS) on psel/penable/paddr/pwrite/pwdata. It waits through slave wait states and returns the read data plus an error flag on a one-cycle response strobe. An optional timeout aborts transfers that never complete.

## Interface
- ADDR_W, 32, width of cmd_addr and paddr
- DATA_W, 32, width of all data buses
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort; only used with APB_MASTER_TIMEOUT_EN; legal range ≥2
- clk  in  1  clock; all logic is rising-edge
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion strobe; no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  transfer aborted by timeout; qualified by rsp_valid
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready; sampled only in ACCESS

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. All APB and rsp_* outputs are registered.
- cmd_ready is combinational: (state == IDLE) && !rsp_valid. The forced gap guarantees at least one cycle with psel=0 between transfers, so the slave returns to its idle state.
- Accept = cmd_valid && cmd_ready at a clock edge.
  - On accept, the bridge latches cmd_addr, cmd_wdata and cmd_write into paddr, pwdata and pwrite.
  - For reads, pwdata is driven to 0.
  - The FSM moves IDLE→SETUP.
- SETUP:
  - psel=1, penable=0.
  - Unconditionally moves to ACCESS on the next edge.
  - pready is ignored.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite and pwdata are held stable.
  - Each edge with pready=0 is a wait state: the FSM stays in ACCESS and the wait counter increments.
- Completion: pready=1 sampled in ACCESS.
  - Next cycle: psel=0, penable=0, rsp_valid=1, rsp_err=0.
  - rsp_rdata = prdata captured at that edge for a read, 0 for a write.
  - The FSM moves to IDLE.
- rsp_rdata and rsp_err hold their values until the next rsp_valid. rsp_valid is high for exactly one cycle.
- The wait counter is $clog2(TIMEOUT_CYCLES)+1 bits wide and is cleared on entry to SETUP.
- Reset mid-transfer: all state and outputs clear immediately. No rsp_valid is issued for the killed command.

## Timing
- Reset values:
  - psel, penable, pwrite = 0
  - paddr, pwdata, rsp_rdata = 0
  - rsp_valid, rsp_err = 0
  - state = IDLE
- Accept at edge N:
  - SETUP occupies cycle N..N+1.
  - First ACCESS cycle is N+1..N+2; pready is first sampled at edge N+2.
- Zero wait states: rsp_valid is high in the cycle after edge N+2, so accept-to-rsp_valid is 3 edges. Each wait state adds 1 edge.
- Earliest next accept is 1 edge after rsp_valid deasserts. Back-to-back throughput is one command per 4 cycles at zero wait states.
- Timeout with pready=0 on the edge that reaches TIMEOUT_CYCLES ACCESS cycles:
  - Abort: next cycle psel/penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - If pready=1 on that same edge, normal completion wins.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - The wait counter and abort path are compiled in.
  - Behaviour is as described under Timing.
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter is built.
  - ACCESS waits indefinitely for pready.
  - rsp_err is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Write 0x0000_0010 / 0xDEAD_BEEF, pready=1 in the first ACCESS cycle:
  - psel high 2 cycles, penable high 1 cycle, paddr/pwdata stable.
  - rsp_valid 3 edges after accept, rsp_err=0, rsp_rdata=0.
- Read 0x0000_0014 with 3 wait states and prdata=0x0000_000A on the ready edge:
  - rsp_rdata=0x0000_000A, rsp_err=0.
  - Latency 6 edges; penable high 4 cycles.
- Timeout enabled, TIMEOUT_CYCLES=16, pready held 0:
  - Abort after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0.
  - A repeat run with pready=1 on the 16th edge gives rsp_err=0.
- cmd_valid held high with 3 queued writes to 0x10/0x14/0x18:
  - Exactly 3 transfers, in order.
  - psel=0 for ≥1 cycle between them, cmd_ready=0 during rsp_valid.
  - Exactly 3 rsp_valid pulses.
- pready forced to 1 during SETUP, then 0 for 2 ACCESS cycles, then 1:
  - SETUP lasts exactly 1 cycle.
  - Completion occurs on the third ACCESS edge, not earlier.
- reset_n asserted asynchronously mid-ACCESS:
  - All outputs are 0 before the next clk edge.
  - No rsp_valid is issued.
  - After release, a fresh read completes normally.

Source files
------------

// File: rtl/alu_apb_master.sv
// alu_apb_master
//   Turns single read/write commands (valid/ready) into one APB transfer each
//   (SETUP then ACCESS). It waits through slave wait states and returns the
//   read data and an error flag on a one-cycle rsp_valid strobe.
//
//   Optional feature macro: APB_MASTER_TIMEOUT_EN
//     defined   : a wait counter aborts ACCESS after TIMEOUT_CYCLES cycles
//                 without pready (rsp_err=1)
//     undefined : ACCESS waits forever for pready, and rsp_err is tied to 0
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write/cmd_addr/cmd_wdata command payload
//   rsp_valid/rsp_rdata/rsp_err  completion strobe, read data, abort flag
//   psel/penable/paddr/pwrite/pwdata/prdata/pready  APB master side
module alu_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic   accept;

  // An illegal timeout would make the abort compare meaningless.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("alu_apb_master: TIMEOUT_CYCLES must be >= 2");
  end

  // Blocking while rsp_valid is high forces one psel=0 cycle between
  // transfers, so the slave always sees its idle state.
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // wait_cnt holds the number of ACCESS edges already spent waiting. The
  // edge that would complete the TIMEOUT_CYCLES-th one aborts.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pwdata  <= cmd_write ? cmd_wdata : '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        SETUP: begin
          // pready is deliberately not looked at here.
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            // Normal completion also wins on the timeout edge.
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (timeout_hit) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_apb_master.sv
module tb_alu_apb_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;

  int total = 0;
  int passed = 0;

  alu_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and act as the APB slave. The slave holds pready low for
  // 'waits' ACCESS edges, then raises it with 'rd' on prdata. Outside the ready
  // edge, prdata carries junk so that a wrong capture edge is visible.
  // 'lat' counts edges from the accept edge, inclusive, to the first cycle
  // where rsp_valid is seen. It is -1 if no response arrives within 'bound'.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input logic setup_rdy,
                         input int bound, output int lat, output int psel_n,
                         output int pen_n, output logic [31:0] rdata, output logic err,
                         output logic stable_ok, output logic rdy_low);
    int acc;
    logic done;
    logic [31:0] expw;
    expw = w ? wd : 32'h0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    lat = -1; psel_n = 0; pen_n = 0; acc = 0; done = 1'b0;
    rdata = '0; err = 1'b0; stable_ok = 1'b1; rdy_low = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      step();
      // Scramble the command inputs so that a missing latch shows up.
      cmd_valid = 1'b0; cmd_addr = 32'h0BAD_0000; cmd_wdata = 32'h5555_5555;
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (psel && (paddr !== a || pwdata !== expw || pwrite !== w)) stable_ok = 1'b0;
      if (rsp_valid) begin
        lat = i; rdata = rsp_rdata; err = rsp_err; rdy_low = !cmd_ready;
        pready = 1'b0; done = 1'b1;
        break;
      end
      if (penable) begin
        pready = (acc >= waits);
        prdata = pready ? rd : (32'hA5A5_0000 | acc);
        acc++;
      end else begin
        pready = setup_rdy;
        prdata = 32'hFFFF_FFFF;
      end
    end
    if (!done) pready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    total++; if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0)
      $display("FAIL reset_ctl: psel=%b penable=%b pwrite=%b, want 000", psel, penable, pwrite); else passed++;
    total++; if (paddr !== 32'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_data: paddr=%h pwdata=%h rsp_rdata=%h, want 0", paddr, pwdata, rsp_rdata); else passed++;
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL reset_rsp: rsp_valid=%b rsp_err=%b cmd_ready=%b, want 0 0 1", rsp_valid, rsp_err, cmd_ready); else passed++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    int lat, ps, pe; logic [31:0] rd; logic er, st, rl;
    run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 20, lat, ps, pe, rd, er, st, rl);
    total++; if (lat !== 3) $display("FAIL wr_latency: got %0d, want 3", lat); else passed++;
    total++; if (ps !== 2 || pe !== 1) $display("FAIL wr_psel_penable: psel=%0d penable=%0d cycles, want 2 1", ps, pe); else passed++;
    total++; if (st !== 1'b1) $display("FAIL wr_stable: got %b, want 1", st); else passed++;
    total++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL wr_rsp: rdata=%h err=%b, want 0 0", rd, er); else passed++;
    total++; if (rl !== 1'b1) $display("FAIL wr_ready_gap: cmd_ready low=%b, want 1", rl); else passed++;
    step();
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL wr_pulse: rsp_valid=%b rsp_rdata=%h, want 0 0", rsp_valid, rsp_rdata); else passed++;
  endtask

  task automatic test_read_waits();
    int lat, ps, pe; logic [31:0] rd; logic er, st, rl;
    run_cmd(1'b0, 32'h0000_0014, 32'hFFFF_0000, 32'h0000_000A, 3, 1'b0, 30, lat, ps, pe, rd, er, st, rl);
    total++; if (lat !== 6) $display("FAIL rd_latency: got %0d, want 6", lat); else passed++;
    total++; if (pe !== 4 || ps !== 5) $display("FAIL rd_penable: psel=%0d penable=%0d cycles, want 5 4", ps, pe); else passed++;
    total++; if (rd !== 32'h0000_000A || er !== 1'b0) $display("FAIL rd_rsp: rdata=%h err=%b, want 0000000a 0", rd, er); else passed++;
    total++; if (st !== 1'b1) $display("FAIL rd_stable: got %b (pwdata must be 0 for reads), want 1", st); else passed++;
    step();
    total++; if (rsp_rdata !== 32'h0000_000A) $display("FAIL rd_hold: rsp_rdata=%h, want 0000000a", rsp_rdata); else passed++;
  endtask

  task automatic test_mid_reset();
    int lat, ps, pe, pulses; logic [31:0] rd; logic er, st, rl;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1234_5678; pready = 1'b0;
    step(); cmd_valid = 1'b0;
    step(); step();
    total++; if (psel !== 1'b1 || penable !== 1'b1) $display("FAIL mr_in_access: psel=%b penable=%b, want 1 1", psel, penable); else passed++;
    #2; reset_n = 1'b0; #1;
    total++; if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 32'h0 || pwdata !== 32'h0)
      $display("FAIL mr_apb_clear: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, want all 0", psel, penable, pwrite, paddr, pwdata); else passed++;
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL mr_rsp_clear: rsp_valid=%b rsp_err=%b rsp_rdata=%h, want all 0", rsp_valid, rsp_err, rsp_rdata); else passed++;
    step(); step();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid || psel) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL mr_no_rsp: activity cycles=%0d, want 0", pulses); else passed++;
    run_cmd(1'b0, 32'h24, 32'h0, 32'h0000_0077, 1, 1'b0, 20, lat, ps, pe, rd, er, st, rl);
    total++; if (lat !== 4 || rd !== 32'h77 || er !== 1'b0)
      $display("FAIL mr_fresh_read: lat=%0d rdata=%h err=%b, want 4 00000077 0", lat, rd, er); else passed++;
    step();
  endtask

  task automatic test_setup_pready();
    int lat, ps, pe; logic [31:0] rd; logic er, st, rl;
    run_cmd(1'b0, 32'h30, 32'h0, 32'hCAFE_0001, 2, 1'b1, 20, lat, ps, pe, rd, er, st, rl);
    total++; if (lat !== 5) $display("FAIL sp_latency: got %0d, want 5", lat); else passed++;
    total++; if (ps - pe !== 1) $display("FAIL sp_setup_len: setup cycles=%0d, want 1", ps - pe); else passed++;
    total++; if (rd !== 32'hCAFE_0001) $display("FAIL sp_rdata: got %h, want cafe0001", rd); else passed++;
    step();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int lat, ps, pe; logic [31:0] rd; logic er, st, rl;
    run_cmd(1'b0, 32'h40, 32'h0, 32'h1111_2222, 1000, 1'b0, 40, lat, ps, pe, rd, er, st, rl);
    total++; if (lat !== 18 || pe !== 16) $display("FAIL to_abort_time: lat=%0d access=%0d, want 18 16", lat, pe); else passed++;
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL to_abort_rsp: err=%b rdata=%h, want 1 0", er, rd); else passed++;
    step();
    run_cmd(1'b0, 32'h44, 32'h0, 32'h3333_4444, 15, 1'b0, 40, lat, ps, pe, rd, er, st, rl);
    total++; if (lat !== 18 || er !== 1'b0 || rd !== 32'h3333_4444)
      $display("FAIL to_ready_wins: lat=%0d err=%b rdata=%h, want 18 0 33334444", lat, er, rd); else passed++;
    step();
  endtask
`else
  task automatic test_long_stall();
    int lat, ps, pe; logic [31:0] rd; logic er, st, rl;
    run_cmd(1'b0, 32'h40, 32'h0, 32'h1111_2222, 20, 1'b0, 60, lat, ps, pe, rd, er, st, rl);
    total++; if (lat !== 23 || pe !== 21) $display("FAIL ls_latency: lat=%0d access=%0d, want 23 21", lat, pe); else passed++;
    total++; if (er !== 1'b0 || rd !== 32'h1111_2222) $display("FAIL ls_rsp: err=%b rdata=%h, want 0 11112222", er, rd); else passed++;
    step();
  endtask
`endif

  task automatic test_back_to_back();
    int idx, last_acc, rsp_n, setup_n;
    logic acc_now, prev_psel, gap_ok, spacing_ok, ready_ok, order_ok;
    idx = 0; last_acc = -1; rsp_n = 0; setup_n = 0; prev_psel = 1'b0;
    gap_ok = 1'b1; spacing_ok = 1'b1; ready_ok = 1'b1; order_ok = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h100;
    pready = 1'b1; prdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 30; c++) begin
      acc_now = cmd_valid && cmd_ready;
      step();
      if (acc_now) begin
        if (last_acc >= 0 && c - last_acc != 4) spacing_ok = 1'b0;
        last_acc = c; idx++;
        if (idx == 3) cmd_valid = 1'b0;
        else begin cmd_addr = 32'h10 + 32'(4 * idx); cmd_wdata = 32'h100 + 32'(idx); end
      end
      if (psel && !penable) begin
        if (paddr !== 32'h10 + 32'(4 * setup_n) || pwdata !== 32'h100 + 32'(setup_n)) order_ok = 1'b0;
        if (prev_psel) gap_ok = 1'b0;
        setup_n++;
      end
      if (rsp_valid) begin
        rsp_n++;
        if (cmd_ready) ready_ok = 1'b0;
      end
      prev_psel = psel;
    end
    pready = 1'b0;
    total++; if (setup_n !== 3 || rsp_n !== 3) $display("FAIL b2b_count: transfers=%0d rsp=%0d, want 3 3", setup_n, rsp_n); else passed++;
    total++; if (order_ok !== 1'b1) $display("FAIL b2b_order: got %b, want 1", order_ok); else passed++;
    total++; if (gap_ok !== 1'b1) $display("FAIL b2b_psel_gap: got %b, want 1", gap_ok); else passed++;
    total++; if (ready_ok !== 1'b1) $display("FAIL b2b_ready_low: got %b, want 1", ready_ok); else passed++;
    total++; if (spacing_ok !== 1'b1) $display("FAIL b2b_spacing: got %b, want 1 (4 cycles)", spacing_ok); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_waits();
    test_mid_reset();
    test_setup_pready();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
